phy_rx_sync_ctrl: RTL

PHY_RX_SYNC_CTRL -- requirements
Module: phy_rx_sync_ctrl

---
 rtl/phy_rx_sync_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/phy_rx_sync_ctrl.sv
// Two-lane receive byte synchroniser: per-lane comma search, payload delivery while locked,
// and loss-of-sync detection on over-long data runs with a saturating resync counter.
module phy_rx_sync_ctrl #(
  parameter logic [7:0]  COMMA        = 8'hBC,
  parameter int unsigned BC_COUNT     = 4,
  parameter int unsigned MAX_DATA_RUN = 32
) (
  input  logic       clk_f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic [7:0] data_in_0,
  input  logic [7:0] data_in_1,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       active_0,
  output logic       active_1,
  output logic       link_active,
  output logic [7:0] resync_cnt_0,
  output logic [7:0] resync_cnt_1
);

  typedef enum logic [1:0] {StDisabled, StSearch, StActive} state_e;

  // Compare against "last" values so the counters never need to exceed their widths.
  localparam logic [2:0] CommaLast = 3'(BC_COUNT - 1);
  localparam logic [5:0] RunLast   = 6'(MAX_DATA_RUN - 1);

  logic [7:0] data_in [2];
  state_e     state_q [2];
  logic [2:0] comma_cnt_q [2];
  logic [5:0] run_cnt_q [2];
  logic [7:0] resync_q [2];
  logic [7:0] data_q [2];
  logic       valid_q [2];
  logic       active_q [2];

  assign data_in[0] = data_in_0;
  assign data_in[1] = data_in_1;

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]     <= StDisabled;
        comma_cnt_q[i] <= 3'd0;
        run_cnt_q[i]   <= 6'd0;
        resync_q[i]    <= 8'd0;
        data_q[i]      <= 8'd0;
        valid_q[i]     <= 1'b0;
        active_q[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!enable) begin
          // Dropping enable abandons sync progress but leaves resync history alone.
          state_q[i]     <= StDisabled;
          comma_cnt_q[i] <= 3'd0;
          run_cnt_q[i]   <= 6'd0;
          valid_q[i]     <= 1'b0;
          active_q[i]    <= 1'b0;
        end else begin
          case (state_q[i])
            StDisabled: begin
              state_q[i]     <= StSearch;
              comma_cnt_q[i] <= 3'd0;
              valid_q[i]     <= 1'b0;
            end
            StSearch: begin
              valid_q[i] <= 1'b0;
              if (data_in[i] == COMMA) begin
                if (comma_cnt_q[i] == CommaLast) begin
                  state_q[i]     <= StActive;
                  active_q[i]    <= 1'b1;
                  comma_cnt_q[i] <= 3'd0;
                  run_cnt_q[i]   <= 6'd0;
                end else begin
                  comma_cnt_q[i] <= comma_cnt_q[i] + 3'd1;
                end
              end else begin
                comma_cnt_q[i] <= 3'd0;
              end
            end
            StActive: begin
              if (data_in[i] == COMMA) begin
                valid_q[i]   <= 1'b0;
                run_cnt_q[i] <= 6'd0;
              end else begin
                data_q[i]  <= data_in[i];
                valid_q[i] <= 1'b1;
                // The byte that hits the run limit is still delivered before sync drops.
                if (run_cnt_q[i] == RunLast) begin
                  state_q[i]     <= StSearch;
                  active_q[i]    <= 1'b0;
                  comma_cnt_q[i] <= 3'd0;
                  run_cnt_q[i]   <= 6'd0;
                  if (resync_q[i] != 8'hFF) begin
                    resync_q[i] <= resync_q[i] + 8'd1;
                  end
                end else begin
                  run_cnt_q[i] <= run_cnt_q[i] + 6'd1;
                end
              end
            end
            default: begin
              state_q[i]  <= StDisabled;
              valid_q[i]  <= 1'b0;
              active_q[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign data_out_0   = data_q[0];
  assign data_out_1   = data_q[1];
  assign valid_out_0  = valid_q[0];
  assign valid_out_1  = valid_q[1];
  assign active_0     = active_q[0];
  assign active_1     = active_q[1];
  assign link_active  = active_q[0] & active_q[1];
  assign resync_cnt_0 = resync_q[0];
  assign resync_cnt_1 = resync_q[1];

endmodule
